// File: rtl/solution_min_weight_if.sv
// AXI-stream style beat bus between a stream producer and consumer.
// Latency: none, wires only. Backpressure: a beat moves when tvalid and tready are both high.
// Ports: tdata (DATA_W), tvalid and tlast (producer to consumer), tready (consumer to producer).
interface axi_stream_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/solution_min_weight.sv
// Rebuilds solution vectors from stream beats and keeps the lowest-weight vector and the vector count.
// Latency: B accepted beats plus 1 EVAL cycle per vector. done rises 1 cycle after the final EVAL, or 1 cycle after an early tlast.
// Backpressure: tready is high only in RECV, so the sender holds its beat during EVAL, DONE and IDLE.
// Ports: clk and rst_n (synchronous, active low); start and vec_length begin a run.
//        solution_stream is the slave side of the beat stream.
//        busy, done, error, min_weight, min_vector and solution_count report the run.
module solution_min_weight #(
  parameter int MAX_VEC_LENGTH   = 16,
  parameter int AXI_DATA_WIDTH   = 8,
  parameter int MAX_VEC_LENGTH_W = $clog2(MAX_VEC_LENGTH + 1),
  parameter int COUNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [MAX_VEC_LENGTH_W-1:0] vec_length,
  axi_stream_if.slave                 solution_stream,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [MAX_VEC_LENGTH_W-1:0] min_weight,
  output logic [MAX_VEC_LENGTH-1:0]   min_vector,
  output logic [COUNT_W-1:0]          solution_count
);

  localparam int W         = AXI_DATA_WIDTH;
  localparam int RAW_BEATS = (MAX_VEC_LENGTH + W - 1) / W;
  localparam int MAX_BEATS = (RAW_BEATS < 1) ? 1 : RAW_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int ASM_W     = MAX_BEATS * W;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_EVAL, S_DONE} state_t;

  state_t                      state_q;
  logic [MAX_VEC_LENGTH_W-1:0] vec_len_q;
  logic [BEAT_W-1:0]           nbeats_q;
  logic [BEAT_W-1:0]           beat_cnt_q;
  logic [ASM_W-1:0]            asm_q;
  logic                        last_q;
  logic                        error_q;
  logic [MAX_VEC_LENGTH_W-1:0] min_weight_q;
  logic [MAX_VEC_LENGTH-1:0]   min_vector_q;
  logic [COUNT_W-1:0]          count_q;

  logic [BEAT_W-1:0]           nbeats_d;
  logic [MAX_VEC_LENGTH-1:0]   vec_masked_d;
  logic [MAX_VEC_LENGTH_W-1:0] weight_d;
  logic                        last_beat;

  // Beats per vector for the incoming vec_length. A zero-length vector still occupies one beat.
  always_comb begin
    int b;
    b = (int'(vec_length) + W - 1) / W;
    if (b == 0) b = 1;
    nbeats_d = BEAT_W'(b);
  end

  // Padding bits above vec_len_q are cleared before they are counted or stored.
  always_comb begin
    vec_masked_d = '0;
    weight_d     = '0;
    for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
      if (i < int'(vec_len_q)) vec_masked_d[i] = asm_q[i];
    end
    for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
      weight_d = weight_d + MAX_VEC_LENGTH_W'(vec_masked_d[i]);
    end
  end

  assign last_beat = (beat_cnt_q == nbeats_q - BEAT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_len_q    <= '0;
      nbeats_q     <= '0;
      beat_cnt_q   <= '0;
      asm_q        <= '0;
      last_q       <= 1'b0;
      error_q      <= 1'b0;
      min_weight_q <= '1;
      min_vector_q <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_len_q    <= vec_length;
            nbeats_q     <= nbeats_d;
            beat_cnt_q   <= '0;
            asm_q        <= '0;
            last_q       <= 1'b0;
            error_q      <= 1'b0;
            min_weight_q <= '1;
            min_vector_q <= '0;
            count_q      <= '0;
            state_q      <= S_RECV;
          end
        end
        S_RECV: begin
          if (solution_stream.tvalid) begin
            asm_q[int'(beat_cnt_q)*W +: W] <= solution_stream.tdata;
            last_q <= solution_stream.tlast;
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= S_EVAL;
            end else if (solution_stream.tlast) begin
              // The stream ended inside a vector. The partial vector is never evaluated.
              error_q    <= 1'b1;
              beat_cnt_q <= '0;
              state_q    <= S_DONE;
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        S_EVAL: begin
          if (count_q != '1) count_q <= count_q + COUNT_W'(1);
          // A strict compare means that on a tie the earlier vector stays.
          if (weight_d < min_weight_q) begin
            min_weight_q <= weight_d;
            min_vector_q <= vec_masked_d;
          end
          state_q <= last_q ? S_DONE : S_RECV;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign solution_stream.tready = (state_q == S_RECV);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign error          = error_q;
  assign min_weight     = min_weight_q;
  assign min_vector     = min_vector_q;
  assign solution_count = count_q;

endmodule

// File: tb/tb_solution_min_weight.sv
// Drives randomized and directed solution streams and checks the results against a popcount reference model.
// Latency checked: tready follows start, tready drops in EVAL, and done arrives 1 cycle after EVAL or after an early tlast.
// Backpressure: the bench holds each beat until tready is seen, with optional random tvalid gaps.
module tb_solution_min_weight;
  localparam int W  = 8;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] vec_length = '0;
  logic          busy, done, error;
  logic [LW-1:0] min_weight;
  logic [ML-1:0] min_vector;
  logic [CW-1:0] solution_count;

  axi_stream_if #(.DATA_W(W)) s_if ();

  solution_min_weight #(
    .MAX_VEC_LENGTH(ML), .AXI_DATA_WIDTH(W), .MAX_VEC_LENGTH_W(LW), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vec_length),
    .solution_stream(s_if), .busy(busy), .done(done), .error(error),
    .min_weight(min_weight), .min_vector(min_vector), .solution_count(solution_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned vecs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int vlen);
    @(negedge clk);
    start = 1'b1;
    vec_length = LW'(vlen);
    @(negedge clk);
    start = 1'b0;
    chk("tready_after_start", 32'(s_if.tready), 1);
  endtask

  task automatic send_beat(input logic [7:0] d, input bit last, input bit gaps);
    int budget;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = last;
    budget = 0;
    while (!s_if.tready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) chk("tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Sends nvec complete vectors from vecs. If err_beat >= 0, a partial vector follows with tlast on that beat.
  task automatic run_scn(input string nm, input int vlen, input int nvec, input int err_beat,
                         input bit gaps, input bit poke);
    int b, ew, cyc, exp_lat;
    int unsigned mask, ev, w;
    bit fin;
    b = (vlen + W - 1) / W;
    if (b == 0) b = 1;
    mask = (32'd1 << vlen) - 32'd1;
    ew = (1 << LW) - 1;
    ev = 0;
    for (int i = 0; i < nvec; i++) begin
      w = $countones(vecs[i] & mask);
      if (int'(w) < ew) begin
        ew = int'(w);
        ev = vecs[i] & mask;
      end
    end
    do_start(vlen);
    for (int i = 0; i < nvec; i++) begin
      fin = (err_beat < 0) && (i == nvec - 1);
      for (int k = 0; k < b; k++) begin
        send_beat(8'((vecs[i] >> (8 * k)) & 32'hFF), fin && (k == b - 1), gaps);
        if (poke && i == 0 && k == 0 && b > 1) begin
          start = 1'b1;
          vec_length = LW'(4);
          @(posedge clk);
          #1;
          start = 1'b0;
          vec_length = LW'(vlen);
        end
      end
      chk({nm, "_tready_eval"}, 32'(s_if.tready), 0);
      if (!fin) begin
        @(posedge clk);
        #1;
        chk({nm, "_tready_back"}, 32'(s_if.tready), 1);
      end
    end
    if (err_beat >= 0) begin
      for (int k = 0; k <= err_beat; k++) send_beat(8'($urandom), k == err_beat, gaps);
    end
    exp_lat = (err_beat >= 0) ? 0 : 1;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_done_lat"}, cyc, exp_lat);
    chk({nm, "_error"}, 32'(error), (err_beat >= 0) ? 1 : 0);
    chk({nm, "_min_weight"}, 32'(min_weight), ew);
    chk({nm, "_min_vector"}, 32'(min_vector), ev);
    chk({nm, "_count"}, 32'(solution_count), nvec);
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, 32'(done), 0);
    chk({nm, "_idle"}, 32'(busy), 0);
    chk({nm, "_hold_weight"}, 32'(min_weight), ew);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_tready"}, 32'(s_if.tready), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_error"}, 32'(error), 0);
    chk({nm, "_min_weight"}, 32'(min_weight), 31);
    chk({nm, "_min_vector"}, 32'(min_vector), 0);
    chk({nm, "_count"}, 32'(solution_count), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vlen, b, nvec, eb;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    vecs = '{32'h0B};              run_scn("single", 4, 1, -1, 0, 0);
    vecs = '{32'h3FF, 32'h201, 32'h0F0}; run_scn("three", 10, 3, -1, 0, 0);
    vecs = '{32'h3, 32'h5};        run_scn("tie", 3, 2, -1, 0, 0);
    vecs = '{32'hF1};              run_scn("pad", 4, 1, -1, 0, 0);
    vecs = '{32'h001};             run_scn("err", 10, 1, 0, 0, 0);
    vecs = '{32'hFF, 32'h5A};      run_scn("len0", 0, 2, -1, 0, 0);
    vecs = '{32'h3FF, 32'h201, 32'h0F0}; run_scn("gaps", 10, 3, -1, 1, 0);
    vecs = '{32'h3FF, 32'h201, 32'h0F0}; run_scn("poke", 10, 3, -1, 0, 1);

    // Reset in the middle of a vector
    do_start(10);
    send_beat(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    vecs = '{32'h3FF, 32'h201, 32'h0F0}; run_scn("after_rst", 10, 3, -1, 0, 0);

    for (int t = 0; t < 10; t++) begin
      vlen = $urandom_range(0, ML);
      b = (vlen + W - 1) / W;
      if (b == 0) b = 1;
      eb = (b >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(0, b - 2) : -1;
      nvec = (eb >= 0) ? $urandom_range(0, 3) : $urandom_range(1, 6);
      vecs = {};
      for (int i = 0; i < nvec; i++) vecs.push_back($urandom & 32'hFFFF);
      run_scn($sformatf("rnd%0d", t), vlen, nvec, eb, $urandom_range(0, 1), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
